// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: strobe edge detection, count prescaler and terminal-count handling
// for a cascaded BCD counter chain. Define STOPWATCH_AUTORELOAD_EN to reload on terminal count.
module stopwatch_ctrl #(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  carry_in,
    output logic                  cnt_clrn,
    output logic                  cnt_ldn,
    output logic                  cnt_enp,
    output logic                  cnt_ent,
    output logic [4*DIGITS-1:0]   cnt_data,
    output logic [1:0]            state,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t              state_q, state_n;
    logic [PS_W-1:0]     ps_q, ps_n;
    logic                start_q, stop_q, clear_q, load_q;
    logic                clrn_n, ldn_n, enp_n, ent_n, done_n;
    logic [4*DIGITS-1:0] data_n;
    logic                start_rise, stop_rise, clear_rise, load_rise, tick;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            ps_q     <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            clear_q  <= 1'b0;
            load_q   <= 1'b0;
            cnt_clrn <= 1'b0;
            cnt_ldn  <= 1'b1;
            cnt_enp  <= 1'b0;
            cnt_ent  <= 1'b0;
            cnt_data <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            ps_q     <= ps_n;
            start_q  <= start;
            stop_q   <= stop;
            clear_q  <= clear;
            load_q   <= load;
            cnt_clrn <= clrn_n;
            cnt_ldn  <= ldn_n;
            cnt_enp  <= enp_n;
            cnt_ent  <= ent_n;
            cnt_data <= data_n;
            done     <= done_n;
        end
    end

    // Only one command acts per edge, in order clear > load > stop > start > tick.
    always_comb begin
        start_rise = start & ~start_q;
        stop_rise  = stop  & ~stop_q;
        clear_rise = clear & ~clear_q;
        load_rise  = load  & ~load_q;
        tick       = (ps_q == PS_LAST);
        state_n    = state_q;
        ps_n       = ps_q;
        clrn_n     = 1'b1;
        ldn_n      = 1'b1;
        enp_n      = 1'b0;
        data_n     = cnt_data;
        done_n     = (state_q == DONE);

        if (clear_rise) begin
            clrn_n  = 1'b0;
            ps_n    = '0;
            state_n = IDLE;
            done_n  = 1'b0;
        end else if (load_rise && (state_q == IDLE || state_q == PAUSE)) begin
            data_n = preset;
            ldn_n  = 1'b0;
        end else if (stop_rise && state_q == RUN) begin
            state_n = PAUSE;
            if (tick) begin
                ps_n = '0;
            end
        end else if (start_rise && (state_q == IDLE || state_q == PAUSE)) begin
            state_n = RUN;
        end else if (state_q == RUN) begin
            if (tick) begin
                ps_n = '0;
                if (carry_in) begin
                    done_n = 1'b1;
`ifdef STOPWATCH_AUTORELOAD_EN
                    ldn_n  = 1'b0;
                    data_n = preset;
`else
                    state_n = DONE;
`endif
                end else begin
                    enp_n = 1'b1;
                end
            end else begin
                ps_n = ps_q + 1'b1;
            end
        end

        ent_n = (state_n == RUN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a BCD counter-chain model supplying carry_in;
// expected outputs are queued per step and compared one edge later.
module tb_stopwatch_ctrl;

    localparam int PRESCALE = 4;
    localparam int DIGITS   = 2;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [7:0] preset = 8'h00;
    logic       carry_in;
    logic       cnt_clrn, cnt_ldn, cnt_enp, cnt_ent, done;
    logic [7:0] cnt_data;
    logic [1:0] state;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       clrn_e;
        logic       ldn_e;
        logic       enp_e;
        logic       ent_e;
        logic       done_e;
        logic [7:0] data_e;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         pulses = 0;
    logic [7:0] cur_data = 8'h00;
    logic [7:0] chain;

    stopwatch_ctrl #(.PRESCALE(PRESCALE), .PS_W(16), .DIGITS(DIGITS)) dut (
        .clk(clk), .clrn(clrn), .start(start), .stop(stop), .clear(clear), .load(load),
        .preset(preset), .carry_in(carry_in), .cnt_clrn(cnt_clrn), .cnt_ldn(cnt_ldn),
        .cnt_enp(cnt_enp), .cnt_ent(cnt_ent), .cnt_data(cnt_data), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_inc(input logic [7:0] c);
        logic [3:0] lo, hi;
        lo = c[3:0];
        hi = c[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Two-digit counter chain driven by the controller outputs
    always @(posedge clk or negedge clrn) begin
        if (!clrn)                    chain <= 8'h00;
        else if (!cnt_clrn)           chain <= 8'h00;
        else if (!cnt_ldn)            chain <= cnt_data;
        else if (cnt_enp && cnt_ent)  chain <= bcd_inc(chain);
    end

    assign carry_in = (chain == 8'h99) && cnt_ent;

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic l,
                                 input logic [7:0] pv);
        start  = s;
        stop   = p;
        clear  = c;
        load   = l;
        preset = pv;
    endtask

    task automatic pushExpect(input string tag, input logic [1:0] st, input logic clr_e,
                              input logic ldn_e, input logic enp_e, input logic ent_e,
                              input logic done_e);
        exp_t e;
        e.tag    = tag;
        e.st     = st;
        e.clrn_e = clr_e;
        e.ldn_e  = ldn_e;
        e.enp_e  = enp_e;
        e.ent_e  = ent_e;
        e.done_e = done_e;
        e.data_e = cur_data;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [14:0] obs, expv;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            obs  = {state, cnt_clrn, cnt_ldn, cnt_enp, cnt_ent, done, cnt_data};
            expv = {e.st, e.clrn_e, e.ldn_e, e.enp_e, e.ent_e, e.done_e, e.data_e};
            checks++;
            assert (obs === expv) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, expv);
            end
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        pushExpect("reset", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        clrn = 1'b1;
        pushExpect("por_release", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Free run: 40 clocks after start give exactly 10 enp pulses
        applyStimulus(1, 0, 0, 0, 8'h00);
        pushExpect("start", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 40; k++) begin
            pushExpect($sformatf("run_k%0d", k), S_RUN, 1'b1, 1'b1, (k % 4 == 0), 1'b1, 1'b0);
            step();
            if (cnt_enp) pulses++;
        end
        checkValue("run_pulses", pulses, 10);
        checkValue("run_chain", int'(chain), 8'h09);

        applyStimulus(0, 0, 1, 0, 8'h00);
        pushExpect("clear1", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        pushExpect("clear1_rel", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Stop at edge 10 (prescaler 1), pause, restart: next enp 3 cycles later
        applyStimulus(1, 0, 0, 0, 8'h00);
        pushExpect("start2", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) applyStimulus(0, 0, 0, 1, 8'h11);
            if (k == 6) applyStimulus(0, 0, 0, 0, 8'h00);
            pushExpect($sformatf("run2_k%0d", k), S_RUN, 1'b1, 1'b1, (k == 4 || k == 8), 1'b1, 1'b0);
            step();
        end
        applyStimulus(0, 1, 0, 0, 8'h00);
        pushExpect("stop", S_PAUSE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            pushExpect($sformatf("pause_k%0d", k), S_PAUSE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1, 0, 0, 0, 8'h00);
        pushExpect("restart", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        for (int j = 1; j <= 8; j++) begin
            pushExpect($sformatf("resume_j%0d", j), S_RUN, 1'b1, 1'b1, (j == 3 || j == 7), 1'b1, 1'b0);
            step();
        end

        applyStimulus(0, 0, 1, 0, 8'h00);
        pushExpect("clear2", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        pushExpect("clear2_rel", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Preset 97, count to 99, then terminal count
        applyStimulus(0, 0, 0, 1, 8'h97);
        cur_data = 8'h97;
        pushExpect("load", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h97);
        pushExpect("load_rel", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checkValue("chain_loaded", int'(chain), 8'h97);
        applyStimulus(1, 0, 0, 0, 8'h97);
        pushExpect("start3", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h97);
        for (int k = 1; k <= 11; k++) begin
            pushExpect($sformatf("run3_k%0d", k), S_RUN, 1'b1, 1'b1, (k == 4 || k == 8), 1'b1, 1'b0);
            step();
        end
`ifdef STOPWATCH_AUTORELOAD_EN
        pushExpect("reload", S_RUN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        pushExpect("reload_after", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checkValue("chain_reloaded", int'(chain), 8'h97);
        for (int j = 1; j <= 3; j++) begin
            pushExpect($sformatf("reload_run_j%0d", j), S_RUN, 1'b1, 1'b1, (j == 3), 1'b1, 1'b0);
            step();
        end
`else
        pushExpect("terminal", S_DONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        for (int k = 1; k <= 5; k++) begin
            pushExpect($sformatf("done_k%0d", k), S_DONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            step();
        end
        checkValue("chain_held", int'(chain), 8'h99);
        applyStimulus(1, 0, 0, 0, 8'h97);
        pushExpect("start_in_done", S_DONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(0, 0, 0, 0, 8'h97);
`endif
        applyStimulus(0, 0, 1, 0, 8'h97);
        pushExpect("clear3", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h97);
        pushExpect("clear3_rel", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Simultaneous clear, load and start: clear alone acts
        applyStimulus(1, 0, 1, 1, 8'h55);
        pushExpect("clr_ld_st", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h55);
        pushExpect("clr_ld_st_rel", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset in the middle of a run
        applyStimulus(1, 0, 0, 0, 8'h55);
        pushExpect("start4", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h55);
        pushExpect("run4", S_RUN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        #2;
        clrn = 1'b0;
        #1;
        cur_data = 8'h00;
        pushExpect("async_reset", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        @(posedge clk);
        #1;
        clrn = 1'b1;
        pushExpect("async_release", S_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
